// File: rtl/if_fetch_pkg.sv
// Shared widths and FSM encodings for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int ADDR_LEN = 32;
    localparam int INST_LEN = 32;
    localparam int BYTE_LEN = 8;
    localparam int BYTES_PER_INST = INST_LEN / BYTE_LEN;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_BUSY = 2'd1,
        IF_DONE = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: four byte reads from an 8-bit memory port assembled into a
// little-endian instruction, with flush on jump and abort when MEM owns the bus.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN,
    parameter int INST_W = INST_LEN,
    parameter int BYTE_W = BYTE_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic [ADDR_W-1:0] pc,
    input  logic              JumpFlag,
    input  logic              mem_busy,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_re,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid,
    output logic              stall_req
);

    if_state_e             r_state;
    if_state_e             w_state_nxt;
    logic [ADDR_W-1:0]     r_fetch_pc;
    logic [2:0]            r_cnt;
    logic [3*BYTE_W-1:0]   r_buf;
    logic [ADDR_W-1:0]     r_mem_a;
    logic                  r_mem_re;
    logic [ADDR_W-1:0]     r_if_pc;
    logic [INST_W-1:0]     r_if_inst;
    logic                  w_start;
    logic                  w_abort;
    logic                  w_unused_stall;

    // Only the IF/ID hold bit matters to this stage.
    assign w_unused_stall = &{1'b0, stall[5:2], stall[0]};

    assign w_start = (r_state == IF_IDLE) && !JumpFlag && !mem_busy;
    assign w_abort = (r_state == IF_BUSY) && (JumpFlag || mem_busy);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IF_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IF_IDLE: if (w_start) w_state_nxt = IF_BUSY;
            IF_BUSY: begin
                if (w_abort)             w_state_nxt = IF_IDLE;
                else if (r_cnt == 3'd4)  w_state_nxt = IF_DONE;
            end
            IF_DONE: if (JumpFlag || !stall[1]) w_state_nxt = IF_IDLE;
            default: w_state_nxt = IF_IDLE;
        endcase
    end

    // Bytes 0..2 shift in from the top, so after three captures r_buf = {b2,b1,b0}.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_a   <= '0;
            r_mem_re  <= 1'b0;
            r_cnt     <= 3'd0;
            r_if_pc   <= '0;
            r_if_inst <= '0;
        end else begin
            case (r_state)
                IF_IDLE: begin
                    if (w_start) begin
                        r_fetch_pc <= pc;
                        r_mem_a    <= pc;
                        r_mem_re   <= 1'b1;
                        r_cnt      <= 3'd0;
                    end else begin
                        r_mem_re   <= 1'b0;
                    end
                end
                IF_BUSY: begin
                    if (w_abort) begin
                        r_mem_re <= 1'b0;
                        r_cnt    <= 3'd0;
                    end else begin
                        if (r_cnt >= 3'd1 && r_cnt <= 3'd3)
                            r_buf <= {mem_din, r_buf[3*BYTE_W-1:BYTE_W]};
                        if (r_cnt <= 3'd2)
                            r_mem_a <= r_fetch_pc + ADDR_W'(r_cnt) + ADDR_W'(1);
                        if (r_cnt == 3'd3)
                            r_mem_re <= 1'b0;
                        if (r_cnt < 3'd4)
                            r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd4) begin
                            r_if_inst <= {mem_din, r_buf};
                            r_if_pc   <= r_fetch_pc;
                        end
                    end
                end
                default: r_mem_re <= 1'b0;
            endcase
        end
    end

    assign mem_a     = r_mem_a;
    assign mem_re    = r_mem_re;
    assign if_pc     = r_if_pc;
    assign if_inst   = r_if_inst;
    assign if_valid  = (r_state == IF_DONE);
    // Letting the pc move during a jump cycle is what loads the jump target.
    assign stall_req = (r_state != IF_DONE) && !JumpFlag;

endmodule
